// File: rtl/alu_sched_if.sv
// alu_sched_if: bus between the scheduler and the shared combinational ALU
//   alu_en      enable, high only while an operation is issued
//   alu_opcode  3-bit operation select
//   alu_a/b     W-bit operands
//   alu_result  2*W-bit result returned by the ALU
//   master: scheduler side (drives en/opcode/a/b)   slave: ALU side (drives result)
interface alu_sched_if #(parameter int W = 4);
   logic           alu_en;
   logic [2:0]     alu_opcode;
   logic [W-1:0]   alu_a;
   logic [W-1:0]   alu_b;
   logic [2*W-1:0] alu_result;
   modport master (output alu_en, alu_opcode, alu_a, alu_b, input alu_result);
   modport slave  (input alu_en, alu_opcode, alu_a, alu_b, output alu_result);
endinterface

// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler sharing one combinational ALU among N_REQ requesters
//   clk, rst          clock, asynchronous active-high reset
//   req/req_op/a/b    per-requester request level and operation (op at [3i+:3], a/b at [Wi+:W])
//   gnt               one-hot registered accept pulse
//   rsp_valid         one-hot result pulse to the winner
//   rsp_data          registered result, held until the next capture
//   err, busy         divide-by-zero flag, high when not idle
//   alu               alu_sched_if master port towards the ALU
// Optional macro ALU_SCHED_DIVZERO_CHK_EN: divide by zero is answered with all ones and err
// instead of being issued to the ALU.
module alu_sched #(
   parameter int N_REQ = 2,
   parameter int W     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req,
   input  logic [3*N_REQ-1:0]   req_op,
   input  logic [W*N_REQ-1:0]   req_a,
   input  logic [W*N_REQ-1:0]   req_b,
   output logic [N_REQ-1:0]     gnt,
   output logic [N_REQ-1:0]     rsp_valid,
   output logic [2*W-1:0]       rsp_data,
   output logic                 err,
   output logic                 busy,
   alu_sched_if.master          alu
);
   localparam int IW = $clog2(N_REQ);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t           state_q, state_d;
   logic [IW-1:0]    last_q, last_d, win_q, win_d, pick, idx;
   logic [2:0]       op_q, op_d, sel_op;
   logic [W-1:0]     a_q, a_d, b_q, b_d, sel_a, sel_b;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [2*W-1:0]   rsp_data_q, rsp_data_d;
   logic             err_q, err_d, found, divz, exec;
   // search starts one past the last winner and wraps, so the first hit is the RR winner
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = IW'((int'(last_q) + k) % N_REQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end
   assign sel_op = req_op[3*pick +: 3];
   assign sel_a  = req_a[W*pick +: W];
   assign sel_b  = req_b[W*pick +: W];
`ifdef ALU_SCHED_DIVZERO_CHK_EN
   assign divz = (sel_op == 3'b010) && (sel_b == '0);
`else
   assign divz = 1'b0;
`endif
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      win_d      = win_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      gnt_d      = '0;
      err_d      = 1'b0;
      rsp_data_d = rsp_data_q;
      if (state_q == EXEC) begin
         rsp_data_d = alu.alu_result;
         state_d    = RESP;
      end else if (found) begin
         // a trapped divide goes straight to RESP with an all-ones answer
         state_d    = divz ? RESP : EXEC;
         last_d     = pick;
         win_d      = pick;
         op_d       = sel_op;
         a_d        = sel_a;
         b_d        = sel_b;
         gnt_d      = N_REQ'(1) << pick;
         rsp_data_d = divz ? '1 : rsp_data_q;
         err_d      = divz;
      end else begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         last_q     <= IW'(N_REQ - 1);
         win_q      <= '0;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         gnt_q      <= '0;
         rsp_data_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         win_q      <= win_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         gnt_q      <= gnt_d;
         rsp_data_q <= rsp_data_d;
         err_q      <= err_d;
      end
   end
   assign exec           = (state_q == EXEC);
   assign alu.alu_en     = exec;
   assign alu.alu_opcode = exec ? op_q : '0;
   assign alu.alu_a      = exec ? a_q : '0;
   assign alu.alu_b      = exec ? b_q : '0;
   assign gnt            = gnt_q;
   assign rsp_valid      = (state_q == RESP) ? N_REQ'(1) << win_q : '0;
   assign rsp_data       = rsp_data_q;
   assign err            = err_q;
   assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed and random checks of alu_sched against a transaction-level model
module tb_alu_sched;
   localparam int N = 2;
   localparam int W = 4;
`ifdef ALU_SCHED_DIVZERO_CHK_EN
   localparam bit DZ = 1'b1;
`else
   localparam bit DZ = 1'b0;
`endif
   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [N-1:0]   req = '0;
   logic [3*N-1:0] req_op = '0;
   logic [W*N-1:0] req_a = '0;
   logic [W*N-1:0] req_b = '0;
   logic [N-1:0]   gnt, rsp_valid;
   logic [2*W-1:0] rsp_data;
   logic           err, busy;
   logic [2:0]     op_r [N];
   logic [W-1:0]   a_r [N];
   logic [W-1:0]   b_r [N];
   int             ptr = N - 1;
   int             checks = 0;
   int             errors = 0;
   alu_sched_if #(.W(W)) alu_bus ();
   alu_sched #(.N_REQ(N), .W(W)) dut (
      .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err), .busy(busy),
      .alu(alu_bus)
   );
   always #5 clk = ~clk;
   function automatic logic [7:0] alu_f(logic [2:0] op, logic [3:0] a, logic [3:0] b);
      int x = int'(a), y = int'(b);
      case (op)
         3'd0:    return 8'(x + y);
         3'd1:    return 8'(x - y);
         3'd2:    return (y == 0) ? 8'd0 : 8'(x / y);
         3'd3:    return 8'(x * y);
         3'd4:    return 8'(x & y);
         3'd5:    return 8'(x | y);
         3'd6:    return 8'(x ^ y);
         default: return 8'(x);
      endcase
   endfunction
   always_comb alu_bus.alu_result = alu_bus.alu_en ? alu_f(alu_bus.alu_opcode, alu_bus.alu_a, alu_bus.alu_b) : 8'd0;
   function automatic int rr_pick(logic [N-1:0] pend);
      for (int k = 1; k <= N; k++)
         if (pend[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction
   task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask
   task automatic pack();
      for (int i = 0; i < N; i++) begin
         req_op[3*i +: 3] = op_r[i];
         req_a[W*i +: W]  = a_r[i];
         req_b[W*i +: W]  = b_r[i];
      end
   endtask
   task automatic set_op(int i, logic [2:0] op, logic [3:0] a, logic [3:0] b);
      op_r[i] = op;
      a_r[i]  = a;
      b_r[i]  = b;
   endtask
   task automatic serve(logic [N-1:0] mask);
      logic [N-1:0] pend = mask;
      int           budget = 0;
      int           w;
      bit           dzc;
      logic [7:0]   e;
      pack();
      req = mask;
      while (pend != 0) begin
         @(negedge clk);
         budget++;
         if (budget > 40) begin
            chk("grant_timeout", 32'(pend), 0);
            req = '0;
            break;
         end
         if (gnt != 0) begin
            w = rr_pick(pend);
            if (w < 0) begin
               chk("spurious_gnt", 32'(gnt), 0);
               continue;
            end
            dzc = DZ && op_r[w] == 3'b010 && b_r[w] == 0;
            chk("gnt", 32'(gnt), 32'(1 << w));
            chk("busy", 32'(busy), 1);
            chk("alu_en", 32'(alu_bus.alu_en), 32'(!dzc));
            chk("alu_opcode", 32'(alu_bus.alu_opcode), dzc ? 0 : 32'(op_r[w]));
            chk("alu_a", 32'(alu_bus.alu_a), dzc ? 0 : 32'(a_r[w]));
            chk("alu_b", 32'(alu_bus.alu_b), dzc ? 0 : 32'(b_r[w]));
            ptr     = w;
            pend[w] = 1'b0;
            req[w]  = 1'b0;
            e = dzc ? 8'hFF : alu_f(op_r[w], a_r[w], b_r[w]);
            if (!dzc) @(negedge clk);
            chk("rsp_valid", 32'(rsp_valid), 32'(1 << w));
            chk("rsp_data", 32'(rsp_data), 32'(e));
            chk("err", 32'(err), 32'(dzc));
         end
      end
   endtask
   task automatic check_reset_outputs();
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_data", 32'(rsp_data), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_alu_en", 32'(alu_bus.alu_en), 0);
      chk("rst_alu_opcode", 32'(alu_bus.alu_opcode), 0);
      chk("rst_alu_a", 32'(alu_bus.alu_a), 0);
      chk("rst_alu_b", 32'(alu_bus.alu_b), 0);
   endtask
   task automatic reset_in_exec();
      int budget = 0;
      set_op(0, 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom_range(1, 15)));
      pack();
      req = 2'b01;
      do begin
         @(negedge clk);
         budget++;
      end while (gnt == 0 && budget < 10);
      chk("pre_rst_gnt", 32'(gnt), 1);
      req = '0;
      #1 rst = 1'b1;
      #1 check_reset_outputs();
      rst = 1'b0;
      ptr = N - 1;
      @(negedge clk);
      chk("post_rst_rsp_valid", 32'(rsp_valid), 0);
      chk("post_rst_busy", 32'(busy), 0);
   endtask
   initial begin
      int w;
      #1 rst = 1'b1;
      #2 check_reset_outputs();
      @(negedge clk);
      rst = 1'b0;
      set_op(0, 3'b000, 4'd9, 4'd8);
      serve(2'b01);
      chk("add_9_8", 32'(rsp_data), 32'd17);
      reset_in_exec();
      set_op(1, 3'b000, 4'd3, 4'd4);
      serve(2'b10);
      reset_in_exec();
      set_op(0, 3'b011, 4'd2, 4'd3);
      set_op(1, 3'b100, 4'd6, 4'd3);
      serve(2'b11);
      set_op(1, 3'b001, 4'd2, 4'd5);
      serve(2'b10);
      chk("sub_wrap", 32'(rsp_data), 32'hFD);
      set_op(0, 3'b011, 4'd15, 4'd15);
      set_op(1, 3'b011, 4'd15, 4'd15);
      pack();
      req = 2'b11;
      w = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i % 2 == 0) begin
            w = rr_pick(2'b11);
            chk("held_gnt", 32'(gnt), 32'(1 << w));
            chk("held_order", 32'(w), 32'((i / 2) % 2));
            ptr = w;
         end else begin
            chk("held_gap", 32'(gnt), 0);
            chk("held_rsp_valid", 32'(rsp_valid), 32'(1 << w));
            chk("held_rsp_data", 32'(rsp_data), 32'd225);
         end
      end
      req = '0;
      set_op(0, 3'b010, 4'd7, 4'd0);
      serve(2'b01);
      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < N; i++) begin
            set_op(i, 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
            if ($urandom_range(0, 3) == 0) set_op(i, 3'b010, 4'($urandom), 4'd0);
         end
         serve(2'($urandom_range(1, 3)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      repeat (3) @(negedge clk);
      chk("final_busy", 32'(busy), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
